// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for a five-stage pipeline: waits on split instruction/data
// memory responses, inserts load-use bubbles, squashes on redirects and counts stalls.
//
// state | meaning
// RUN   | pipeline advanced last cycle
// STALL | pipeline held last cycle, waiting on a memory response
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             br_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             imem_read,
    output logic             dmem_go,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_i_done;
    logic             r_d_done;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_i_ok;
    logic w_d_ok;
    logic w_advance;
    logic w_hazard;

    assign w_i_ok    = r_i_done | imem_resp;
    assign w_d_ok    = ~dmem_req | r_d_done | dmem_resp;
    assign w_advance = w_i_ok & w_d_ok & ~rst;
    assign w_hazard  = ex_is_load & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign imem_read = ~rst & ~r_i_done;
    assign dmem_go   = ~rst & dmem_req & ~r_d_done;
    assign stalled   = (r_state == STALL);
    assign stall_cnt = r_stall_cnt;

    // A redirect squashes the younger instructions, so it wins over a load-use bubble.
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (w_advance) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (br_taken) begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (w_hazard) begin
                flush_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                RUN:     if (!w_advance) r_state <= STALL;
                STALL:   if (w_advance)  r_state <= RUN;
                default: r_state <= RUN;
            endcase

            // Flags remember responses that arrived while the other side was still pending.
            if (w_advance) begin
                r_i_done <= 1'b0;
                r_d_done <= 1'b0;
            end else begin
                if (imem_resp)             r_i_done <= 1'b1;
                if (dmem_resp && dmem_req) r_d_done <= 1'b1;
            end

            if (!w_advance && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

endmodule
